conv_stream_loader: RTL and testbench

Upstream feeder and result collector for the 3x3-filter / 4x4-input systolic convolution array. It accepts a byte stream over a valid/ready handshake and assembles 16 input pixels and 9 filter weights into parallel registers that drive the array. It then holds the array in reset, releases it, and waits a fixed compute window. It captures the four 8-bit results and presents them downstream with a valid/ready handshake.

---
 rtl/conv_stream_loader_if.sv | 30 +++
 rtl/conv_stream_loader.sv | 127 ++++++++++++
 tb/tb_conv_stream_loader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_loader_if.sv
// ============================================================================
// Module   : conv_stream_loader_if
// Brief    : Byte-stream input and result-output handshakes of the loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface conv_stream_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]   s_data;
  logic                s_first;
  logic                s_valid;
  logic                s_ready;
  logic [4*DATA_W-1:0] res_out;
  logic                res_valid;
  logic                res_ready;

  modport master (
    output s_data, s_first, s_valid, res_ready,
    input  s_ready, res_out, res_valid
  );

  modport slave (
    input  s_data, s_first, s_valid, res_ready,
    output s_ready, res_out, res_valid
  );
endinterface

`default_nettype wire

// File: rtl/conv_stream_loader.sv
// ============================================================================
// Module   : conv_stream_loader
// Brief    : Loads pixels/weights for the systolic conv array, runs it, and
//            hands the captured results downstream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv_stream_loader #(
  parameter int DATA_W     = 8,
  parameter int N_IN       = 16,
  parameter int N_FIL      = 9,
  parameter int RUN_CYCLES = 16
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  conv_stream_loader_if.slave          bus,
  output logic [N_IN*DATA_W-1:0]       in_flat,
  output logic [N_FIL*DATA_W-1:0]      fil_flat,
  output logic                         arr_rst,
  input  wire logic [4*DATA_W-1:0]     res_in,
  output logic                         busy
);

  localparam int             IDX_W     = 5;
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(N_IN + N_FIL - 1);
  localparam logic [4:0]     LAST_RUN  = 5'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [IDX_W-1:0]    idx, idx_nx, wr_slot;
  logic [4:0]          cnt, cnt_nx;
  logic                wr_en, capture, xfer;
  logic                res_valid_q, res_valid_nx;
  logic [4*DATA_W-1:0] res_q;

  assign bus.s_ready   = (state == LOAD) & rst;
  assign bus.res_out   = res_q;
  assign bus.res_valid = res_valid_q;
  assign xfer          = bus.s_valid & bus.s_ready;
  assign arr_rst       = (state != RUN);
  assign busy          = (state == RUN) | (state == DONE);

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    cnt_nx       = cnt;
    wr_en        = 1'b0;
    wr_slot      = idx;
    capture      = 1'b0;
    res_valid_nx = res_valid_q;
    case (state)
      LOAD: begin
        if (xfer) begin
          wr_en = 1'b1;
          // s_first resynchronises the frame without clearing earlier slots
          if (bus.s_first) begin
            wr_slot = '0;
            idx_nx  = IDX_W'(1);
          end else begin
            idx_nx = idx + IDX_W'(1);
            if (idx == LAST_SLOT) begin
              state_nx = RUN;
              cnt_nx   = '0;
            end
          end
        end
      end
      RUN: begin
        cnt_nx = cnt + 5'd1;
        if (cnt == LAST_RUN) begin
          capture      = 1'b1;
          res_valid_nx = 1'b1;
          state_nx     = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_nx = 1'b0;
          idx_nx       = '0;
          state_nx     = LOAD;
        end
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD;
      idx         <= '0;
      cnt         <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      in_flat     <= '0;
      fil_flat    <= '0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      res_valid_q <= res_valid_nx;
      if (capture) begin
        res_q <= res_in;
      end
      if (wr_en) begin
        for (int k = 0; k < N_IN; k++) begin
          if (wr_slot == IDX_W'(k)) begin
            in_flat[(N_IN-1-k)*DATA_W +: DATA_W] <= bus.s_data;
          end
        end
        for (int k = 0; k < N_FIL; k++) begin
          if (wr_slot == IDX_W'(N_IN + k)) begin
            fil_flat[(N_FIL-1-k)*DATA_W +: DATA_W] <= bus.s_data;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_stream_loader.sv
// ============================================================================
// Module   : tb_conv_stream_loader
// Brief    : Scoreboard bench for conv_stream_loader with a behavioural array.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_conv_stream_loader;
  localparam int RUN_CYCLES = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] in_flat;
  logic [71:0]  fil_flat;
  logic         arr_rst;
  logic [31:0]  res_in;
  logic         busy;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           last_xfer_cyc = 0;
  int           xfers = 0;
  bit           prev_valid = 1'b0;
  logic [31:0]  sb[$];

  conv_stream_loader_if #(.DATA_W(8)) sif ();

  conv_stream_loader #(
    .DATA_W(8), .N_IN(16), .N_FIL(9), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .bus(sif), .in_flat(in_flat), .fil_flat(fil_flat),
    .arr_rst(arr_rst), .res_in(res_in), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 3x3 valid convolution over a 4x4 tile, results truncated to 8 bits
  function automatic logic [31:0] conv(input logic [127:0] inf, input logic [71:0] fl);
    logic [31:0] r;
    logic [7:0]  s;
    r = '0;
    for (int ro = 0; ro < 2; ro++) begin
      for (int co = 0; co < 2; co++) begin
        s = 8'd0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            s = s + 8'(inf[(15-((ro+i)*4+co+j))*8 +: 8] * fl[(8-(i*3+j))*8 +: 8]);
          end
        end
        r[(3-(ro*2+co))*8 +: 8] = s;
      end
    end
    return r;
  endfunction

  always_comb res_in = arr_rst ? 32'd0 : conv(in_flat, fil_flat);

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (sif.s_valid && sif.s_ready) begin
        xfers++;
        last_xfer_cyc = cyc + 1;
      end
      if (sif.res_valid && !prev_valid)
        check_val("res_latency", 128'(cyc - last_xfer_cyc), 128'(RUN_CYCLES));
      prev_valid = sif.res_valid;
      if (sif.res_valid && sif.res_ready) begin
        if (sb.size() == 0) check_val("res_unexpected", 1, 0);
        else check_val("res_out", sif.res_out, sb.pop_front());
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit first, input bit gap);
    int t;
    if (gap) begin
      while ($urandom_range(0, 1) == 1) begin
        sif.s_valid = 1'b0;
        sif.s_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_first = first;
    t = 0;
    while (!sif.s_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check_val("s_ready_timeout", 0, 1);
    @(posedge clk); #1;
    sif.s_valid = 1'b0;
    sif.s_first = 1'b0;
  endtask

  task automatic run_frame(input logic [127:0] inf, input logic [71:0] fl, input bit gap, input bit push);
    int x0;
    x0 = xfers;
    if (push) sb.push_back(conv(inf, fl));
    for (int k = 0; k < 16; k++) send_byte(inf[(15-k)*8 +: 8], k == 0, gap);
    for (int k = 0; k < 9; k++)  send_byte(fl[(8-k)*8 +: 8], 1'b0, gap);
    check_val("frame_xfers", 128'(xfers - x0), 128'd25);
    check_val("frame_in_flat", in_flat, inf);
    check_val("frame_fil_flat", 128'(fil_flat), 128'(fl));
    check_val("frame_arr_rst", arr_rst, 1'b0);
  endtask

  task automatic wait_result();
    int t;
    t = 0;
    while (!sif.res_valid && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check_val("res_valid_seen", sif.res_valid, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] inf;
    logic [71:0]  fl;
    logic [31:0]  held;
    logic [7:0]   top;
    int           c0;
    int           t;

    sif.s_data = '0; sif.s_first = 1'b0; sif.s_valid = 1'b0; sif.res_ready = 1'b1;
    #3;
    check_val("rst_s_ready", sif.s_ready, 1'b0);
    check_val("rst_arr_rst", arr_rst, 1'b1);
    check_val("rst_res_valid", sif.res_valid, 1'b0);
    check_val("rst_in_flat", in_flat, 128'd0);
    check_val("rst_res_out", sif.res_out, 32'd0);
    check_val("rst_busy", busy, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // all-ones frame, streamed back to back
    inf = {16{8'h01}};
    fl  = {9{8'h01}};
    c0  = cyc;
    run_frame(inf, fl, 1'b0, 1'b1);
    check_val("t1_consecutive", 128'(cyc - c0), 128'd25);
    check_val("t1_busy", busy, 1'b1);
    wait_result();
    check_val("t1_pulse_1cyc", sif.res_valid, 1'b0);
    check_val("t1_s_ready_back", sif.s_ready, 1'b1);

    // ramp pixels 1..16
    for (int k = 0; k < 16; k++) inf[(15-k)*8 +: 8] = 8'(k + 1);
    run_frame(inf, fl, 1'b0, 1'b1);
    wait_result();

    // downstream stall with the upstream still offering bytes
    sif.res_ready = 1'b0;
    for (int k = 0; k < 16; k++) inf[(15-k)*8 +: 8] = 8'($urandom);
    for (int k = 0; k < 9; k++)  fl[(8-k)*8 +: 8]   = 8'($urandom_range(0, 7));
    run_frame(inf, fl, 1'b0, 1'b1);
    sif.s_valid = 1'b1;
    sif.s_data  = 8'h55;
    t = 0;
    while (!sif.res_valid && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    held = sif.res_out;
    for (int k = 0; k < 10; k++) begin
      check_val("t3_valid_hold", sif.res_valid, 1'b1);
      check_val("t3_out_hold", sif.res_out, held);
      check_val("t3_s_ready_low", sif.s_ready, 1'b0);
      @(posedge clk); #1;
    end
    sif.res_ready = 1'b1;
    @(posedge clk); #1;
    check_val("t3_valid_drop", sif.res_valid, 1'b0);
    check_val("t3_s_ready_high", sif.s_ready, 1'b1);
    sif.s_valid = 1'b0;
    @(posedge clk); #1;

    // resync: 7 bytes, then 0xAA flagged first, then 24 more
    for (int k = 0; k < 7; k++) send_byte(8'(8'h10 + k), k == 0, 1'b0);
    inf[127:120] = 8'hAA;
    for (int k = 1; k < 16; k++) inf[(15-k)*8 +: 8] = 8'(8'h20 + k);
    for (int k = 0; k < 9; k++)  fl[(8-k)*8 +: 8]   = 8'(k + 2);
    sb.push_back(conv(inf, fl));
    send_byte(8'hAA, 1'b1, 1'b0);
    for (int k = 1; k < 16; k++) send_byte(inf[(15-k)*8 +: 8], 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)  send_byte(fl[(8-k)*8 +: 8], 1'b0, 1'b0);
    check_val("t4_still_load", busy, 1'b0);
    send_byte(fl[7:0], 1'b0, 1'b0);
    check_val("t4_run", arr_rst, 1'b0);
    top = in_flat[127:120];
    check_val("t4_slot0", top, 8'hAA);
    check_val("t4_in_flat", in_flat, inf);
    wait_result();

    // reset while the array is running; that frame must vanish
    run_frame(inf, fl, 1'b0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check_val("t5_arr_rst", arr_rst, 1'b1);
    check_val("t5_res_valid", sif.res_valid, 1'b0);
    check_val("t5_in_flat", in_flat, 128'd0);
    check_val("t5_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
    end
    check_val("t5_no_result", sif.res_valid, 1'b0);
    for (int k = 0; k < 16; k++) inf[(15-k)*8 +: 8] = 8'(3 * k + 1);
    run_frame(inf, fl, 1'b0, 1'b1);
    wait_result();

    // gapped stream must map slots exactly as the ramp frame
    for (int k = 0; k < 16; k++) inf[(15-k)*8 +: 8] = 8'(k + 1);
    fl = {9{8'h01}};
    run_frame(inf, fl, 1'b1, 1'b1);
    wait_result();

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check_val("sb_drained", 128'(sb.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
